// File: rtl/ptp_rx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ptp_rx_pkg
// Brief    : Field offsets, message types, register map and record type for
//            the PTPv2 receive parser.
// Revision : 1.0 - initial release
// ============================================================================
package ptp_rx_pkg;

    // Payload byte offsets within the PTPv2 common header and timestamp
    localparam logic [6:0] c_off_type       = 7'd0;
    localparam logic [6:0] c_off_version    = 7'd1;
    localparam logic [6:0] c_off_domain     = 7'd4;
    localparam logic [6:0] c_off_corr_first = 7'd8;
    localparam logic [6:0] c_off_corr_last  = 7'd15;
    localparam logic [6:0] c_off_src_first  = 7'd20;
    localparam logic [6:0] c_off_src_last   = 7'd29;
    localparam logic [6:0] c_off_seq_first  = 7'd30;
    localparam logic [6:0] c_off_seq_last   = 7'd31;
    localparam logic [6:0] c_off_hdr_last   = 7'd33;
    localparam logic [6:0] c_off_sec_first  = 7'd34;
    localparam logic [6:0] c_off_sec_last   = 7'd39;
    localparam logic [6:0] c_off_ns_first   = 7'd40;
    localparam logic [6:0] c_off_ns_last    = 7'd43;

    localparam logic [3:0] c_ptp_version    = 4'd2;

    localparam logic [3:0] c_msg_sync       = 4'h0;
    localparam logic [3:0] c_msg_delay_req  = 4'h1;
    localparam logic [3:0] c_msg_follow_up  = 4'h8;
    localparam logic [3:0] c_msg_delay_resp = 4'h9;

    localparam logic [7:0] c_reg_status     = 8'h00;
    localparam logic [7:0] c_reg_ctrl       = 8'h04;
    localparam logic [7:0] c_reg_ts_ns      = 8'h08;
    localparam logic [7:0] c_reg_ts_sec_lo  = 8'h0C;
    localparam logic [7:0] c_reg_ts_sec_hi  = 8'h10;
    localparam logic [7:0] c_reg_corr_lo    = 8'h14;
    localparam logic [7:0] c_reg_corr_hi    = 8'h18;
    localparam logic [7:0] c_reg_src_hi     = 8'h1C;
    localparam logic [7:0] c_reg_src_mid    = 8'h20;
    localparam logic [7:0] c_reg_src_port   = 8'h24;
    localparam logic [7:0] c_reg_cnt_rx     = 8'h28;
    localparam logic [7:0] c_reg_cnt_drop   = 8'h2C;
    localparam logic [7:0] c_reg_pop        = 8'h30;

    typedef struct packed {
        logic [3:0]  msg_type;
        logic [7:0]  domain;
        logic [63:0] correction;
        logic [79:0] src_id;
        logic [15:0] seq_id;
        logic [47:0] ts_sec;
        logic [31:0] ts_ns;
    } ptp_rx_rec_t;

    function automatic logic type_accepted(input logic [3:0] msg_type, input logic accept_all);
        return accept_all
            || (msg_type == c_msg_sync)      || (msg_type == c_msg_delay_req)
            || (msg_type == c_msg_follow_up) || (msg_type == c_msg_delay_resp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptp_rx_regs.sv
`default_nettype none
// ============================================================================
// Module   : ptp_rx_regs
// Brief    : Wishbone register file, held record, counters and POP/overflow.
// Revision : 1.0 - initial release
// ============================================================================
module ptp_rx_regs
    import ptp_rx_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_wdata,
    output logic [31:0] o_wb_rdata,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic        o_wb_ack,
    input  logic        i_frame_end,
    input  logic        i_commit_ok,
    input  ptp_rx_rec_t i_rec,
    output logic [9:0]  o_ctrl,
    output logic        o_valid
);

    logic              r_ack;
    logic [31:0]       r_rdata;
    logic [31:0]       r_ctrl;
    logic              r_valid;
    logic              r_ovf;
    ptp_rx_rec_t       r_held;
    logic [CNT_W-1:0]  r_cnt_rx;
    logic [CNT_W-1:0]  r_cnt_drop;

    logic [7:0]        w_reg_off;
    logic              w_access;
    logic              w_wr;
    logic              w_pop;
    logic              w_take;
    logic [31:0]       w_rdata;
    logic              w_unused_addr;

    assign w_reg_off     = {i_wb_addr[7:2], 2'b00};
    assign w_unused_addr = ^{i_wb_addr[31:8], i_wb_addr[1:0]};
    assign w_access      = i_wb_stb & ~r_ack;
    assign w_wr          = w_access & i_wb_we;
    assign w_pop         = w_wr && (w_reg_off == c_reg_pop);
    // A POP landing on the commit beat frees the slot for the new record
    assign w_take        = i_frame_end & i_commit_ok & (~r_valid | w_pop);

    assign o_wb_ack   = r_ack;
    assign o_wb_rdata = r_rdata;
    assign o_ctrl     = r_ctrl[9:0];
    assign o_valid    = r_valid;

    always_comb begin
        w_rdata = '0;
        case (w_reg_off)
            c_reg_status:    w_rdata = {r_held.seq_id, 8'h00, r_held.msg_type, 2'b00, r_ovf, r_valid};
            c_reg_ctrl:      w_rdata = r_ctrl;
            c_reg_ts_ns:     w_rdata = r_held.ts_ns;
            c_reg_ts_sec_lo: w_rdata = r_held.ts_sec[31:0];
            c_reg_ts_sec_hi: w_rdata = {16'h0000, r_held.ts_sec[47:32]};
            c_reg_corr_lo:   w_rdata = r_held.correction[31:0];
            c_reg_corr_hi:   w_rdata = r_held.correction[63:32];
            c_reg_src_hi:    w_rdata = r_held.src_id[79:48];
            c_reg_src_mid:   w_rdata = r_held.src_id[47:16];
            c_reg_src_port:  w_rdata = {8'h00, r_held.domain, r_held.src_id[15:0]};
            c_reg_cnt_rx:    w_rdata = 32'(r_cnt_rx);
            c_reg_cnt_drop:  w_rdata = 32'(r_cnt_drop);
            default:         w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_ctrl     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_held     <= '0;
            r_cnt_rx   <= '0;
            r_cnt_drop <= '0;
        end else begin
            r_ack <= w_access;
            if (w_access) begin
                r_rdata <= i_wb_we ? 32'h0 : w_rdata;
            end
            if (w_wr && (w_reg_off == c_reg_ctrl)) begin
                r_ctrl <= i_wb_wdata;
            end
            if (w_wr && (w_reg_off == c_reg_status) && i_wb_wdata[1]) begin
                r_ovf <= 1'b0;
            end
            if (w_pop) begin
                r_valid <= 1'b0;
            end
            if (i_frame_end) begin
                if (w_take) begin
                    r_held   <= i_rec;
                    r_valid  <= 1'b1;
                    r_cnt_rx <= r_cnt_rx + CNT_W'(1);
                end else begin
                    r_cnt_drop <= r_cnt_drop + CNT_W'(1);
                    if (i_commit_ok) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ptp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module   : ptp_rx_parser
// Brief    : AXI-Stream PTPv2 payload parser with filtering and a Wishbone
//            readable single-entry message record.
// Revision : 1.0 - initial release
// ============================================================================
module ptp_rx_parser
    import ptp_rx_pkg::*;
#(
    parameter int MIN_LEN = 44,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_data_i,
    output logic [31:0] wbs_data_o,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    output logic        wbs_ack_o,
    input  logic [7:0]  axis_tdata_i,
    input  logic        axis_tvalid_i,
    output logic        axis_tready_o,
    input  logic        axis_tlast_i,
    input  logic        axis_tuser_i,
    output logic        irq_o
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_hdr  = 2'd1;
    localparam logic [1:0] c_st_body = 2'd2;
    localparam logic [1:0] c_st_drop = 2'd3;

    localparam logic [7:0] c_min_len = 8'(MIN_LEN);
    localparam logic [6:0] c_cnt_max = 7'd127;

    logic [1:0]  r_state;
    logic [6:0]  r_byte_cnt;
    logic        r_tready;
    ptp_rx_rec_t r_work;

    ptp_rx_rec_t w_work_next;
    logic [9:0]  w_ctrl;
    logic        w_beat;
    logic        w_frame_end;
    logic        w_hdr_bad;
    logic        w_commit_ok;

    assign axis_tready_o = r_tready;
    assign w_beat        = axis_tvalid_i & r_tready;
    assign w_frame_end   = w_beat & axis_tlast_i;

    // Fields arrive MSB first, so each multi-byte field is shifted in
    always_comb begin
        w_work_next = r_work;
        if (w_beat && (r_state != c_st_drop)) begin
            if (r_byte_cnt == c_off_type)
                w_work_next.msg_type = axis_tdata_i[3:0];
            if (r_byte_cnt == c_off_domain)
                w_work_next.domain = axis_tdata_i;
            if ((r_byte_cnt >= c_off_corr_first) && (r_byte_cnt <= c_off_corr_last))
                w_work_next.correction = {r_work.correction[55:0], axis_tdata_i};
            if ((r_byte_cnt >= c_off_src_first) && (r_byte_cnt <= c_off_src_last))
                w_work_next.src_id = {r_work.src_id[71:0], axis_tdata_i};
            if ((r_byte_cnt >= c_off_seq_first) && (r_byte_cnt <= c_off_seq_last))
                w_work_next.seq_id = {r_work.seq_id[7:0], axis_tdata_i};
            if ((r_byte_cnt >= c_off_sec_first) && (r_byte_cnt <= c_off_sec_last))
                w_work_next.ts_sec = {r_work.ts_sec[39:0], axis_tdata_i};
            if ((r_byte_cnt >= c_off_ns_first) && (r_byte_cnt <= c_off_ns_last))
                w_work_next.ts_ns = {r_work.ts_ns[23:0], axis_tdata_i};
        end
    end

    assign w_hdr_bad = (r_byte_cnt == c_off_version)
                    && (!type_accepted(r_work.msg_type, w_ctrl[9])
                        || (axis_tdata_i[3:0] != c_ptp_version));

    assign w_commit_ok = (r_state != c_st_drop) && !axis_tuser_i
                      && (({1'b0, r_byte_cnt} + 8'd1) >= c_min_len)
                      && (!w_ctrl[8] || (w_work_next.domain == w_ctrl[7:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_byte_cnt <= '0;
            r_tready   <= 1'b0;
            r_work     <= '0;
        end else begin
            r_tready <= 1'b1;
            if (w_beat) begin
                r_work <= w_work_next;
                if (axis_tlast_i) begin
                    r_state    <= c_st_idle;
                    r_byte_cnt <= '0;
                end else begin
                    if (r_byte_cnt != c_cnt_max) begin
                        r_byte_cnt <= r_byte_cnt + 7'd1;
                    end
                    case (r_state)
                        c_st_idle: r_state <= c_st_hdr;
                        c_st_hdr: begin
                            if (w_hdr_bad)
                                r_state <= c_st_drop;
                            else if (r_byte_cnt == c_off_hdr_last)
                                r_state <= c_st_body;
                        end
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end

    ptp_rx_regs #(
        .CNT_W (CNT_W)
    ) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wb_addr   (wbs_addr_i),
        .i_wb_wdata  (wbs_data_i),
        .o_wb_rdata  (wbs_data_o),
        .i_wb_we     (wbs_we_i),
        .i_wb_stb    (wbs_stb_i),
        .o_wb_ack    (wbs_ack_o),
        .i_frame_end (w_frame_end),
        .i_commit_ok (w_commit_ok),
        .i_rec       (w_work_next),
        .o_ctrl      (w_ctrl),
        .o_valid     (irq_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ptp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptp_rx_parser
// Brief    : Self-checking bench for ptp_rx_parser against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptp_rx_parser;

    localparam int MIN_LEN = 44;
    localparam int CNT_W   = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbs_addr_i = '0;
    logic [31:0] wbs_data_i = '0;
    logic [31:0] wbs_data_o;
    logic        wbs_we_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_ack_o;
    logic [7:0]  axis_tdata_i = '0;
    logic        axis_tvalid_i = 1'b0;
    logic        axis_tready_o;
    logic        axis_tlast_i = 1'b0;
    logic        axis_tuser_i = 1'b0;
    logic        irq_o;

    ptp_rx_parser #(.MIN_LEN(MIN_LEN), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wbs_addr_i    (wbs_addr_i),
        .wbs_data_i    (wbs_data_i),
        .wbs_data_o    (wbs_data_o),
        .wbs_we_i      (wbs_we_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_ack_o     (wbs_ack_o),
        .axis_tdata_i  (axis_tdata_i),
        .axis_tvalid_i (axis_tvalid_i),
        .axis_tready_o (axis_tready_o),
        .axis_tlast_i  (axis_tlast_i),
        .axis_tuser_i  (axis_tuser_i),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame buffer and reference model state
    logic [7:0]  frm [0:199];
    logic        m_valid, m_ovf;
    logic [31:0] m_ctrl, m_rx, m_drop;
    logic [3:0]  h_type;
    logic [7:0]  h_dom;
    logic [63:0] h_corr;
    logic [79:0] h_src;
    logic [15:0] h_seq;
    logic [47:0] h_sec;
    logic [31:0] h_ns;
    logic [31:0] d;

    task automatic model_reset();
        m_valid = 0; m_ovf = 0; m_ctrl = 0; m_rx = 0; m_drop = 0;
        h_type = 0; h_dom = 0; h_corr = 0; h_src = 0; h_seq = 0; h_sec = 0; h_ns = 0;
    endtask

    function automatic logic type_ok(input logic [3:0] t);
        return m_ctrl[9] || (t == 4'd0) || (t == 4'd1) || (t == 4'd8) || (t == 4'd9);
    endfunction

    task automatic model_frame(input int len, input logic tuser, input logic pop);
        logic ok;
        ok = !tuser && (len >= MIN_LEN) && type_ok(frm[0][3:0]) && (frm[1][3:0] == 4'd2)
             && (!m_ctrl[8] || (frm[4] == m_ctrl[7:0]));
        if (ok && (!m_valid || pop)) begin
            h_type = frm[0][3:0];
            h_dom  = frm[4];
            h_corr = {frm[8], frm[9], frm[10], frm[11], frm[12], frm[13], frm[14], frm[15]};
            h_src  = {frm[20], frm[21], frm[22], frm[23], frm[24], frm[25], frm[26], frm[27], frm[28], frm[29]};
            h_seq  = {frm[30], frm[31]};
            h_sec  = {frm[34], frm[35], frm[36], frm[37], frm[38], frm[39]};
            h_ns   = {frm[40], frm[41], frm[42], frm[43]};
            m_valid = 1;
            m_rx++;
        end else if (ok) begin
            m_ovf = 1;
            m_drop++;
        end else begin
            m_drop++;
            if (pop) m_valid = 0;
        end
    endtask

    function automatic logic [31:0] exp_reg(input int idx);
        case (idx)
            0:  return {h_seq, 8'h00, h_type, 2'b00, m_ovf, m_valid};
            1:  return m_ctrl;
            2:  return h_ns;
            3:  return h_sec[31:0];
            4:  return {16'h0000, h_sec[47:32]};
            5:  return h_corr[31:0];
            6:  return h_corr[63:32];
            7:  return h_src[79:48];
            8:  return h_src[47:16];
            9:  return {8'h00, h_dom, h_src[15:0]};
            10: return m_rx;
            11: return m_drop;
            default: return 32'h0;
        endcase
    endfunction

    // All bus/stream tasks start and end 1 time unit after a rising edge
    task automatic wb_xfer(input logic [31:0] a, input logic [31:0] wd, input logic we, output logic [31:0] rd_o);
        int n;
        wbs_addr_i = a; wbs_data_i = wd; wbs_we_i = we; wbs_stb_i = 1'b1;
        n = 0;
        @(posedge clk); #1;
        while (!wbs_ack_o && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wb_ack", wbs_ack_o, 1);
        rd_o = wbs_data_o;
        wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge clk); #1;
        chk("wb_ack_single", wbs_ack_o, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        logic [7:0]  off;
        wb_xfer(a, wd, 1'b1, dummy);
        off = {a[7:2], 2'b00};
        if (off == 8'h00 && wd[1]) m_ovf = 0;
        if (off == 8'h04) m_ctrl = wd;
        if (off == 8'h30) m_valid = 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] rd_v;
        logic [31:0] a;
        for (int r = 0; r < 16; r++) begin
            a = ($urandom & 32'hFFFF_FF00) | 32'(r * 4);
            wb_xfer(a, $urandom, 1'b0, rd_v);
            chk($sformatf("%s_reg%02h", tag, r * 4), rd_v, exp_reg(r));
        end
        chk({tag, "_irq"}, irq_o, m_valid);
        chk({tag, "_tready"}, axis_tready_o, 1);
    endtask

    task automatic build(input logic [3:0] typ, input logic [3:0] ver, input logic [7:0] dom);
        for (int i = 0; i < 200; i++) frm[i] = 8'($urandom);
        frm[0][3:0] = typ;
        frm[1][3:0] = ver;
        frm[4] = dom;
    endtask

    task automatic set_seq(input logic [15:0] seq);
        frm[30] = seq[15:8];
        frm[31] = seq[7:0];
    endtask

    task automatic send_frame(input int len, input logic tuser, input logic pop, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                axis_tvalid_i = 1'b0;
                axis_tdata_i  = 8'($urandom);
                @(posedge clk); #1;
            end
            axis_tvalid_i = 1'b1;
            axis_tdata_i  = frm[i];
            axis_tlast_i  = (i == len - 1);
            axis_tuser_i  = (i == len - 1) ? tuser : 1'($urandom);
            if (i == len - 1 && pop) begin
                wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_addr_i = 32'h30; wbs_data_i = $urandom;
            end
            @(posedge clk); #1;
            if (i == len - 1 && pop) begin
                chk("pop_at_last_ack", wbs_ack_o, 1);
                wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
            end
        end
        axis_tvalid_i = 1'b0; axis_tlast_i = 1'b0; axis_tuser_i = 1'b0;
        @(posedge clk); #1;
        model_frame(len, tuser, pop);
    endtask

    initial begin
        logic [31:0] c;
        int          len;
        logic [3:0]  typ, ver;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("tready_in_reset", axis_tready_o, 0);
        chk("irq_in_reset", irq_o, 0);
        chk("ack_in_reset", wbs_ack_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tready_after_reset", axis_tready_o, 1);
        check_all("reset");

        // Directed Sync with known fields
        build(4'h0, 4'd2, 8'd0);
        set_seq(16'h1234);
        frm[34] = 0; frm[35] = 0; frm[36] = 0; frm[37] = 0; frm[38] = 0; frm[39] = 8'h05;
        frm[40] = 8'h1D; frm[41] = 8'hCD; frm[42] = 8'h65; frm[43] = 8'h00;
        send_frame(44, 1'b0, 1'b0, 0);
        wb_xfer(32'h00, 0, 1'b0, d); chk("sync_status", d, 32'h1234_0001);
        wb_xfer(32'h08, 0, 1'b0, d); chk("sync_ts_ns", d, 32'h1DCD_6500);
        wb_xfer(32'h0C, 0, 1'b0, d); chk("sync_ts_sec_lo", d, 32'h5);
        wb_xfer(32'h28, 0, 1'b0, d); chk("sync_cnt_rx", d, 32'h1);
        chk("sync_irq", irq_o, 1);
        check_all("sync");

        // Overflow on a second Sync, then POP and overflow clear
        build(4'h0, 4'd2, 8'd0); set_seq(16'h5678);
        send_frame(44, 1'b0, 1'b0, 10);
        check_all("ovf");
        wr(32'h30, 32'h0);
        check_all("pop");
        wr(32'h00, 32'h2);
        check_all("ovf_clr");

        // Short frame and errored frame
        build(4'h0, 4'd2, 8'd0); send_frame(30, 1'b0, 1'b0, 0);
        build(4'h0, 4'd2, 8'd0); send_frame(44, 1'b1, 1'b0, 0);
        check_all("short_err");

        // Domain filter
        wr(32'h04, 32'h105);
        build(4'h0, 4'd2, 8'd3); send_frame(44, 1'b0, 1'b0, 0);
        check_all("dom3");
        build(4'h0, 4'd2, 8'd5); send_frame(44, 1'b0, 1'b0, 0);
        check_all("dom5");

        // Announce filtered, then accepted with accept-all
        wr(32'h30, 32'h0);
        build(4'hB, 4'd2, 8'd5); send_frame(48, 1'b0, 1'b0, 0);
        check_all("announce_drop");
        wr(32'h04, 32'h305);
        build(4'hB, 4'd2, 8'd5); send_frame(48, 1'b0, 1'b0, 0);
        check_all("announce_ok");

        // POP on the commit beat keeps the new record
        build(4'h9, 4'd2, 8'd5); set_seq(16'hBEEF);
        send_frame(44, 1'b0, 1'b1, 0);
        check_all("pop_commit");

        wr(32'h38, $urandom);
        check_all("unmapped_wr");

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(9))
                0: begin
                    c = $urandom;
                    c[7:0] = 8'($urandom_range(3));
                    c[8]   = 1'($urandom_range(1));
                    c[9]   = ($urandom_range(3) == 0);
                    wr(32'h04, c);
                end
                1: wr(32'h30, $urandom);
                2: wr(32'h00, $urandom);
                default: ;
            endcase
            case ($urandom_range(9))
                0: len = $urandom_range(43, 1);
                1: len = $urandom_range(150, 128);
                default: len = $urandom_range(60, 44);
            endcase
            case ($urandom_range(4))
                0: typ = 4'h0;
                1: typ = 4'h1;
                2: typ = 4'h8;
                3: typ = 4'h9;
                default: typ = 4'($urandom);
            endcase
            ver = ($urandom_range(7) == 0) ? 4'($urandom) : 4'd2;
            build(typ, ver, 8'($urandom_range(3)));
            send_frame(len, ($urandom_range(9) == 0), ($urandom_range(7) == 0), 20);
            check_all($sformatf("rnd%0d", it));
        end

        // Asynchronous reset in the middle of a frame
        build(4'h0, 4'd2, 8'd0);
        for (int i = 0; i < 20; i++) begin
            axis_tvalid_i = 1'b1; axis_tdata_i = frm[i]; axis_tlast_i = 1'b0;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midframe_rst_tready", axis_tready_o, 0);
        chk("midframe_rst_irq", irq_o, 0);
        axis_tvalid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_all("post_rst");
        build(4'h8, 4'd2, 8'd1); set_seq(16'hCAFE);
        send_frame(44, 1'b0, 1'b0, 0);
        check_all("post_rst_frame");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ptp_rx_parser.md
Name: ptp_rx_parser

Overview:
- Receive-side counterpart of ptp_gen: an AXI-Stream slave that consumes de-encapsulated PTPv2 UDP payload bytes from the GMII/UDP receive path.
- Parses the common header and the 10-byte origin/receive timestamp, then filters by message type, version, length and domain.
- Commits one message record into a held register set that the SoC reads over the Wishbone slave port.
- Sits in the gmii_tx_clk[0] domain beside ptp_gen and occupies one interconnect slave slot.

Parameters:
- MIN_LEN, 44: minimum payload bytes for a valid frame (34-byte header plus 10-byte timestamp).
- CNT_W, 32: width of the accepted-frame and dropped-frame counters.

Ports:
- clk  in  1  system clock (gmii_tx_clk[0]).
- rst_n  in  1  reset, asynchronous, active-low.
- wbs_addr_i  in  32  Wishbone address; bits [7:2] select the register.
- wbs_data_i  in  32  Wishbone write data.
- wbs_data_o  out  32  Wishbone read data.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_ack_o  out  1  Wishbone acknowledge.
- axis_tdata_i  in  8  payload byte.
- axis_tvalid_i  in  1  byte valid.
- axis_tready_o  out  1  ready.
- axis_tlast_i  in  1  last byte of frame.
- axis_tuser_i  in  1  frame error; sampled with tlast.
- irq_o  out  1  high while the held record is valid.

Behaviour:
Reset values:
- All outputs 0; axis_tready_o goes to 1 on the first clk after reset deassertion.
- All registers, counters and the FSM reset asynchronously.

Streaming:
- axis_tready_o stays 1 at all times; the block never backpressures.
- A byte transfers on tvalid & tready.

FSM:
- IDLE → HDR on the first beat.
- HDR → BODY once byte_cnt reaches 34.
- HDR/BODY → IDLE on a tlast beat; the commit decision is made on that beat.
- HDR → DROP when byte 0[3:0] is not in the accept set, or byte 1[3:0] != 2. DROP → IDLE on tlast.

Byte counting:
- byte_cnt is 7 bits, saturates at 127, and clears on tlast.
- Bytes at offset 44 and beyond are ignored.

Field capture into the working set (big-endian):
- msg_type: byte 0[3:0]
- domain: byte 4
- correction: bytes 8-15 (64 bit)
- src_id: bytes 20-29 (80 bit)
- seq_id: bytes 30-31
- ts_sec: bytes 34-39 (48 bit)
- ts_ns: bytes 40-43

Accept set:
- Types 0 (Sync), 1 (Delay_Req), 8 (Follow_Up), 9 (Delay_Resp).
- When CTRL[9] is set, every type is accepted.

Commit on a tlast beat happens when all of the following hold:
- State is not DROP.
- tuser = 0.
- byte_cnt + 1 >= MIN_LEN.
- The domain matches CTRL[7:0], or CTRL[8] = 0.

Commit outcome:
- If the held record is not valid, or POP is written in the same cycle: copy the working set to the held set, set valid, and increment cnt_rx.
- Otherwise the new record is lost: set overflow (sticky) and increment cnt_drop.
- A frame rejected for any reason increments cnt_drop.
- Both counters wrap at 2^CNT_W.

Simultaneous events:
- A POP and a commit in the same cycle leave valid = 1 holding the new record.
- A POP with nothing held is ignored.

Wishbone:
- wbs_ack_o rises the cycle after stb and drops the following cycle (ack <= stb & ~ack), so there is one ack per access.
- Reads are registered and present on the ack cycle.
- Unmapped addresses read 0 and writes to them are ignored.

Register map (byte offsets):
- 0x00 STATUS: [0] valid, [1] overflow, [7:4] msg_type, [31:16] seq_id. Writing bit1 = 1 clears overflow.
- 0x04 CTRL: RW, reset value 0.
- 0x08 TS_NS.
- 0x0C TS_SEC_LO.
- 0x10 TS_SEC_HI[15:0].
- 0x14 CORR_LO.
- 0x18 CORR_HI.
- 0x1C SRC_ID bytes 20-23.
- 0x20 SRC_ID bytes 24-27.
- 0x24 SRC_PORT bytes 28-29 in [15:0], domain in [23:16].
- 0x28 CNT_RX.
- 0x2C CNT_DROP.
- 0x30 POP: any write clears valid.

Decomposition:
- Package ptp_rx_pkg holds:
  - field byte offsets;
  - message-type constants;
  - register offset localparams;
  - a packed struct ptp_rx_rec_t for the working and held sets.
- Sub-module ptp_rx_regs holds the Wishbone decode, the held-record storage, CTRL, the counters and the POP/overflow logic.
- The top level keeps the FSM and field capture.

Test Plan:
- Sync, 44 bytes, seq 0x1234, sec 0x0000_0000_0005, ns 0x1DCD_6500 → STATUS = 0x1234_0001, TS_NS = 0x1DCD6500, TS_SEC_LO = 5, CNT_RX = 1, irq_o = 1.
- Second Sync before POP → STATUS[1] = 1, CNT_DROP = 1, held seq unchanged. POP write → valid = 0; writing STATUS 0x2 → overflow = 0.
- Frame of 30 bytes with tlast, and a separate 44-byte frame with tuser = 1 at tlast → no commit, CNT_DROP += 2.
- CTRL = 0x105 with domain-3 Sync → dropped. Domain-5 Sync → accepted.
- Type 0xB (Announce) → dropped. With CTRL[9] = 1 → accepted with msg_type 0xB.
- POP write lands on the tlast-commit cycle → valid stays 1 with the new seq. Assert rst_n mid-frame → all registers 0, and the next full frame parses correctly.
